// File: rtl/ppg_fir_scheduler.sv
// ppg_fir_scheduler: dual-channel 22-tap symmetric FIR sharing one serial MAC engine.
// Ports: CLK_Filter clock, rst_n async active-low reset; ir_*/red_* valid-ready sample
// inputs; out_valid/out_chan/out_data filtered result; busy high while not IDLE.
// Optional PPG_HIST_FLUSH_EN adds input flush that clears both histories in IDLE.
module ppg_fir_scheduler #(
  parameter int SAMPLE_W = 8,
  parameter int OUT_W = 20
) (
  input  logic                CLK_Filter,
  input  logic                rst_n,
`ifdef PPG_HIST_FLUSH_EN
  input  logic                flush,
`endif
  input  logic                ir_valid,
  input  logic [SAMPLE_W-1:0] ir_sample,
  output logic                ir_ready,
  input  logic                red_valid,
  input  logic [SAMPLE_W-1:0] red_sample,
  output logic                red_ready,
  output logic                out_valid,
  output logic                out_chan,
  output logic [OUT_W-1:0]    out_data,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, MAC, DONE} state_t;
  localparam logic [7:0] COEF [11] = '{8'd2, 8'd10, 8'd16, 8'd28, 8'd43, 8'd60, 8'd78, 8'd95, 8'd111, 8'd122, 8'd128};
  state_t state, state_n;
  logic [SAMPLE_W-1:0] ir_h [22];
  logic [SAMPLE_W-1:0] red_h [22];
  logic [SAMPLE_W-1:0] sample_q, xa, xb;
  logic [3:0] k;
  logic [4:0] kb;
  logic [8:0] pair;
  logic [16:0] prod;
  logic [OUT_W-1:0] acc;
  logic last_red, chan_q, fl, idle, grant_ir, grant_red, accept;
`ifdef PPG_HIST_FLUSH_EN
  assign fl = flush && state == IDLE;
`else
  assign fl = 1'b0;
`endif
  // Flush takes the IDLE cycle, so no channel is granted while it is high.
  assign idle = state == IDLE && rst_n && !fl;
  // Round-robin: on a tie the channel not served last wins.
  assign grant_ir = ir_valid && (!red_valid || last_red);
  assign grant_red = red_valid && (!ir_valid || !last_red);
  assign ir_ready = idle && grant_ir;
  assign red_ready = idle && grant_red;
  assign accept = ir_ready || red_ready;
  assign busy = state != IDLE;
  assign kb = 5'd21 - {1'b0, k};
  assign xa = chan_q ? red_h[{1'b0, k}] : ir_h[{1'b0, k}];
  assign xb = chan_q ? red_h[kb] : ir_h[kb];
  assign pair = {1'b0, xa} + {1'b0, xb};
  assign prod = 17'(COEF[k]) * 17'(pair);
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (accept ? SHIFT : IDLE) :
              state == SHIFT ? MAC :
              state == MAC   ? (k == 4'd10 ? DONE : MAC) : IDLE;
  end
  always_ff @(posedge CLK_Filter or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 22; i++) begin
        ir_h[i] <= '0;
        red_h[i] <= '0;
      end
      sample_q <= '0;
      chan_q <= 1'b0;
      last_red <= 1'b1;
      k <= '0;
      acc <= '0;
      out_valid <= 1'b0;
      out_chan <= 1'b0;
      out_data <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          sample_q <= ir_ready ? ir_sample : red_sample;
          chan_q <= red_ready;
          last_red <= red_ready;
        end
        if (fl)
          for (int i = 0; i < 22; i++) begin
            ir_h[i] <= '0;
            red_h[i] <= '0;
          end
      end else if (state == SHIFT) begin
        for (int i = 21; i > 0; i--) begin
          if (chan_q) red_h[i] <= red_h[i-1];
          else ir_h[i] <= ir_h[i-1];
        end
        if (chan_q) red_h[0] <= sample_q;
        else ir_h[0] <= sample_q;
        acc <= '0;
        k <= '0;
      end else if (state == MAC) begin
        acc <= acc + OUT_W'(prod);
        k <= k + 4'd1;
      end else begin
        out_data <= acc;
        out_chan <= chan_q;
        out_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ppg_fir_scheduler.sv
// tb_ppg_fir_scheduler: table, directed and random checks of ppg_fir_scheduler against a tap-sum model.
module tb_ppg_fir_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ir_valid = 1'b0, red_valid = 1'b0;
  logic [7:0] ir_sample = '0, red_sample = '0;
  logic ir_ready, red_ready, out_valid, out_chan, busy;
  logic [19:0] out_data;
`ifdef PPG_HIST_FLUSH_EN
  logic flush = 1'b0;
`endif
  int tests = 0, fails = 0;
  int cf [11] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128};
  int hist [2][22];
  int last_data;
  typedef struct {logic [7:0] s; int exp;} vec_t;
  vec_t vt [23];
  always #5 clk = ~clk;
  ppg_fir_scheduler dut (
    .CLK_Filter(clk),
    .rst_n(rst_n),
`ifdef PPG_HIST_FLUSH_EN
    .flush(flush),
`endif
    .ir_valid(ir_valid),
    .ir_sample(ir_sample),
    .ir_ready(ir_ready),
    .red_valid(red_valid),
    .red_sample(red_sample),
    .red_ready(red_ready),
    .out_valid(out_valid),
    .out_chan(out_chan),
    .out_data(out_data),
    .busy(busy)
  );
  function automatic void check(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction
  function automatic void model_clear();
    for (int c = 0; c < 2; c++)
      for (int t = 0; t < 22; t++) hist[c][t] = 0;
  endfunction
  function automatic void model_push(int c, int s);
    for (int t = 21; t > 0; t--) hist[c][t] = hist[c][t-1];
    hist[c][0] = s;
  endfunction
  // Each tap t weighted by its mirrored coefficient, summed directly.
  function automatic int model_out(int c);
    int sum = 0;
    for (int t = 0; t < 22; t++) sum += cf[t < 11 ? t : 21 - t] * hist[c][t];
    return sum;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ir_valid = 1'b0;
    red_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask
  task automatic do_txn(input int ch, input logic [7:0] s);
    int n, exp;
    bit got;
    @(negedge clk);
    if (ch == 1) begin red_valid = 1'b1; red_sample = s; end
    else begin ir_valid = 1'b1; ir_sample = s; end
    #1;
    n = 0;
    while (!(ch == 1 ? red_ready : ir_ready) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept_wait", int'(n < 40), 1);
    @(posedge clk);
    #1;
    ir_valid = 1'b0;
    red_valid = 1'b0;
    model_push(ch, s);
    exp = model_out(ch);
    n = 0;
    got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_after_accept", int'(busy), 1);
      if (out_valid) got = 1;
    end
    check("latency", n, 14);
    check("out_data", int'(out_data), exp);
    check("out_chan", int'(out_chan), ch);
    check("busy_at_result", int'(busy), 0);
    last_data = int'(out_data);
    @(negedge clk);
    check("out_valid_pulse", int'(out_valid), 0);
  endtask
  initial begin
    int acc_ch[$], acc_cyc[$], res_ch[$];
    model_clear();
    repeat (2) @(negedge clk);
    ir_valid = 1'b1;
    #1;
    check("reset_ir_ready", int'(ir_ready), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_busy", int'(busy), 0);
    ir_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // Tie: both channels request continuously right after reset.
    @(negedge clk);
    ir_valid = 1'b1; ir_sample = 8'd5;
    red_valid = 1'b1; red_sample = 8'd9;
    for (int c = 0; c < 58; c++) begin
      #1;
      if (ir_ready) begin acc_ch.push_back(0); acc_cyc.push_back(c); end
      if (red_ready) begin acc_ch.push_back(1); acc_cyc.push_back(c); end
      if (out_valid) res_ch.push_back(int'(out_chan));
      @(negedge clk);
    end
    ir_valid = 1'b0;
    red_valid = 1'b0;
    check("tie_accepts", int'(acc_ch.size() >= 4), 1);
    check("tie_results", int'(res_ch.size() >= 4), 1);
    for (int i = 0; i < 4 && i < acc_ch.size(); i++) check("tie_order", acc_ch[i], i % 2);
    for (int i = 1; i < 4 && i < acc_cyc.size(); i++) check("tie_spacing", acc_cyc[i] - acc_cyc[i-1], 14);
    for (int i = 0; i < 4 && i < res_ch.size(); i++) check("tie_out_chan", res_ch[i], i % 2);
    repeat (20) @(negedge clk);
    do_reset();
    // Impulse table.
    for (int i = 0; i < 23; i++) begin
      vt[i].s = i == 0 ? 8'd1 : 8'd0;
      vt[i].exp = i < 11 ? cf[i] : i < 22 ? cf[21 - i] : 0;
    end
    for (int i = 0; i < 23; i++) begin
      do_txn(0, vt[i].s);
      check("impulse", last_data, vt[i].exp);
    end
    // Step.
    do_reset();
    for (int i = 0; i < 22; i++) begin
      do_txn(0, 8'd255);
      if (i == 0) check("step_first", last_data, 510);
      if (i == 21) check("step_full", last_data, 353430);
    end
    // Isolation: red impulse interleaved with IR constant.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_txn(0, 8'd10);
      check("iso_ir", last_data, 10 * (i < 11 ? 2 * 0 + 0 : 0) + model_out(0));
      do_txn(1, i == 0 ? 8'd200 : 8'd0);
      if (i == 0) check("iso_red_first", last_data, 400);
    end
    // Random traffic.
    for (int i = 0; i < 30; i++) do_txn(int'($urandom_range(1)), 8'($urandom_range(255)));
    // Reset during MAC k=5.
    @(negedge clk);
    ir_valid = 1'b1; ir_sample = 8'd50;
    #1;
    while (!ir_ready) begin @(negedge clk); #1; end
    @(posedge clk);
    #1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_ir_ready", int'(ir_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_data", int'(out_data), 0);
    ir_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    begin
      int seen = 0;
      repeat (10) begin @(negedge clk); if (out_valid) seen++; end
      check("rst_no_result", seen, 0);
    end
    do_txn(0, 8'd7);
    check("rst_then_7", last_data, 14);
`ifdef PPG_HIST_FLUSH_EN
    for (int i = 0; i < 22; i++) do_txn(0, 8'd255);
    @(negedge clk);
    flush = 1'b1;
    ir_valid = 1'b1; ir_sample = 8'd3;
    #1;
    check("flush_no_grant", int'(ir_ready), 0);
    @(negedge clk);
    flush = 1'b0;
    ir_valid = 1'b0;
    model_clear();
    do_txn(0, 8'd3);
    check("flush_result", last_data, 6);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ppg_fir_scheduler.md
PPG_FIR_SCHEDULER -- requirements
Module: ppg_fir_scheduler

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 8, ADC sample width; only 8 is supported.
REQ-002 SHALL have parameter OUT_W, default 20, filtered result width; only 20 is supported.
REQ-003 SHALL have ports CLK_Filter  in  1  sole clock, rising-edge.
REQ-004 SHALL have ports rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports ir_valid  in  1, ir_sample  in  8, ir_ready  out  1: IR channel sample handshake.
REQ-006 SHALL have ports red_valid  in  1, red_sample  in  8, red_ready  out  1: Red channel sample handshake.
REQ-007 SHALL have ports out_valid  out  1, out_chan  out  1 (0=IR, 1=Red), out_data  out  20: filtered result; busy  out  1: engine not IDLE.

Function
REQ-008 SHALL keep a private 22-entry, 8-bit sample history per channel; one shared serial multiply-accumulate engine serves both channels.
REQ-009 SHALL use fixed symmetric coefficients c0..c10 = 2,10,16,28,43,60,78,95,111,122,128; tap k and tap 21-k share ck.
REQ-010 SHALL implement states IDLE, SHIFT, MAC, DONE; IDLE->SHIFT on an accepted sample; SHIFT->MAC; MAC holds 11 cycles (k=0..10) then ->DONE; DONE->IDLE.
REQ-011 SHALL assert ir_ready/red_ready only in IDLE and only for the granted channel; a sample is accepted when valid and ready are both high on a rising edge.
REQ-012 SHALL grant round-robin: a single requester wins; both requesting -> the channel not served last; the last-served pointer resets to Red, so IR wins the first tie.
REQ-013 SHALL, in SHIFT, shift the granted channel history by one (x[21] discarded) and write the accepted sample to x[0].
REQ-014 SHALL, in MAC cycle k, add ck*(x[k]+x[21-k]) to an unsigned accumulator cleared at SHIFT; x[k]+x[21-k] is 9 bits and the accumulator is 20 bits.
REQ-015 SHALL, in DONE, register the accumulator to out_data, drive out_chan, and pulse out_valid high for exactly one cycle; out_data and out_chan hold until the next DONE.
REQ-016 SHALL, for a sample accepted at edge T, assert out_valid during the cycle following edge T+13 (fixed latency 13 cycles); the next accept is possible at edge T+14.
REQ-017 SHALL never overflow: the maximum result is 255*2*693 = 353430 < 2^20; no saturation logic is required.
REQ-018 SHALL leave the non-granted channel history untouched; a held valid with a stable sample on that channel waits without loss.
REQ-019 SHALL drive busy high in SHIFT, MAC, and DONE.

Reset
REQ-020 SHALL, on rst_n low at any time including mid-MAC, immediately force IDLE, clear both histories, the accumulator, out_data=0, out_chan=0, out_valid=0, and set the pointer to Red; no result is emitted for an interrupted computation.
REQ-021 SHALL drive ready outputs low while rst_n is low.

Configuration
REQ-022 SHALL, with PPG_HIST_FLUSH_EN defined, add input flush (1 bit); flush high in IDLE zeroes both histories on that edge and suppresses grant for that cycle; flush outside IDLE is ignored.
REQ-023 SHALL, without PPG_HIST_FLUSH_EN, have no flush port; histories clear only by reset.

Verification
REQ-024 SHALL test impulse: IR samples 1 then 21 zeros, red idle -> IR out_data sequence 2,10,16,28,43,60,78,95,111,122,128,128,122,...,2, then 0.
REQ-025 SHALL test step: 22 IR samples of 255 -> the 22nd result = 353430, and the 1st result = 510.
REQ-026 SHALL test tie: both valid continuously -> accepts alternate IR, Red, IR, Red, each 14 cycles apart, and out_chan alternates 0,1,0,1.
REQ-027 SHALL test isolation: Red impulse 200 interleaved with IR constant 10 -> IR results unaffected by Red; the first Red result = 400.
REQ-028 SHALL test reset mid-MAC: rst_n low at MAC k=5 -> no out_valid, and the next IR sample 7 yields out_data 14.
REQ-029 SHALL test flush (PPG_HIST_FLUSH_EN): after IR history is filled with 255, a flush followed by sample 3 -> out_data 6.
